// File: rtl/qracc_bus_dma.sv
// qracc_bus_dma: credit-limited bus-master DMA between system memory and the accelerator bus.
// Define QRACC_DMA_CHECKSUM_EN to add checksum_o, the running sum of words popped per transfer.
module qracc_bus_dma #(
    parameter int dataWidth  = 32,
    parameter int addrWidth  = 32,
    parameter int lenWidth   = 16,
    parameter int fifoDepth  = 4,
    parameter int addrStride = 4
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 start_i,
    input  logic                 dir_i,
    input  logic [addrWidth-1:0] src_addr_i,
    input  logic [addrWidth-1:0] dst_addr_i,
    input  logic [lenWidth-1:0]  len_i,
    input  logic                 abort_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 aborted_o,
    output logic                 mem_rd_req_o,
    output logic [addrWidth-1:0] mem_rd_addr_o,
    input  logic                 mem_rd_gnt_i,
    input  logic                 mem_rd_valid_i,
    input  logic [dataWidth-1:0] mem_rd_data_i,
    output logic                 mem_wr_en_o,
    output logic [addrWidth-1:0] mem_wr_addr_o,
    output logic [dataWidth-1:0] mem_wr_data_o,
    input  logic                 mem_wr_ready_i,
    output logic [addrWidth-1:0] bus_addr_o,
    output logic                 bus_wr_en_o,
    output logic                 bus_rd_en_o,
    output logic [dataWidth-1:0] bus_data_o,
    input  logic [dataWidth-1:0] bus_data_i,
    input  logic                 bus_rd_valid_i,
`ifdef QRACC_DMA_CHECKSUM_EN
    output logic [dataWidth-1:0] checksum_o,
`endif
    input  logic                 bus_stall_i
);

    localparam int PW = $clog2(fifoDepth);
    localparam logic [PW:0] DEPTH = (PW+1)'(fifoDepth);
    localparam logic [addrWidth-1:0] STRIDE = addrWidth'(addrStride);

    typedef enum logic [1:0] {IDLE, XFER, DRAIN, DONE} state_t;

    state_t state_q, state_d;
    logic                 dir_q, aborted_q;
    logic [addrWidth-1:0] src_q, dst_q;
    logic [lenWidth-1:0]  len_q, req_cnt_q, wr_cnt_q;
    logic [PW:0]          inflight_q, wptr_q, rptr_q, count;
    logic [dataWidth-1:0] fifo_q [fifoDepth];
    logic [dataWidth-1:0] head, rsp_data;
    logic busy, kill, accept, credit, issue;
    logic fire, rsp, rsp_dec, push, pop, empty;

    assign busy   = (state_q == XFER) || (state_q == DRAIN);
    assign kill   = busy && abort_i;
    assign accept = (state_q == IDLE) && start_i && (inflight_q == '0);
    assign count  = wptr_q - rptr_q;
    assign empty  = (count == '0);
    assign head   = fifo_q[rptr_q[PW-1:0]];

    // Outstanding requests plus buffered words bound FIFO occupancy.
    assign credit = (inflight_q + count) < DEPTH;
    assign issue  = (state_q == XFER) && credit && !abort_i
                    && (req_cnt_q != len_q);

    assign mem_rd_req_o = issue && !dir_q;
    assign bus_rd_en_o  = issue && dir_q && !bus_stall_i;
    assign fire = (mem_rd_req_o && mem_rd_gnt_i) || bus_rd_en_o;

    assign rsp      = dir_q ? bus_rd_valid_i : mem_rd_valid_i;
    assign rsp_data = dir_q ? bus_data_i : mem_rd_data_i;
    assign rsp_dec  = rsp && (inflight_q != '0);
    assign push     = rsp && busy && !abort_i;

    assign bus_wr_en_o = busy && !dir_q && !empty && !bus_stall_i && !abort_i;
    assign mem_wr_en_o = busy && dir_q && !empty && !abort_i;
    assign pop = bus_wr_en_o || (mem_wr_en_o && mem_wr_ready_i);

    assign mem_rd_addr_o = mem_rd_req_o ? src_q : '0;
    assign mem_wr_addr_o = mem_wr_en_o ? dst_q : '0;
    assign mem_wr_data_o = mem_wr_en_o ? head : '0;
    assign bus_data_o    = bus_wr_en_o ? head : '0;
    assign bus_addr_o    = bus_wr_en_o ? dst_q :
                           bus_rd_en_o ? src_q : '0;

    assign busy_o    = busy;
    assign done_o    = (state_q == DONE);
    assign aborted_o = aborted_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = (len_i == '0) ? DONE : XFER;
            XFER: begin
                if (kill)
                    state_d = IDLE;
                else if (fire && (lenWidth'(req_cnt_q + 1'b1) == len_q))
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (kill)
                    state_d = IDLE;
                else if ((wr_cnt_q == len_q) && empty)
                    state_d = DONE;
            end
            DONE: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            dir_q      <= 1'b0;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            req_cnt_q  <= '0;
            wr_cnt_q   <= '0;
            aborted_q  <= 1'b0;
            inflight_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                dir_q     <= dir_i;
                src_q     <= src_addr_i;
                dst_q     <= dst_addr_i;
                len_q     <= len_i;
                req_cnt_q <= '0;
                wr_cnt_q  <= '0;
                aborted_q <= 1'b0;
            end else begin
                if (fire) begin
                    req_cnt_q <= req_cnt_q + 1'b1;
                    src_q     <= src_q + STRIDE;
                end
                if (pop) begin
                    wr_cnt_q <= wr_cnt_q + 1'b1;
                    dst_q    <= dst_q + STRIDE;
                end
            end
            if (kill) aborted_q <= 1'b1;
            if (fire && !rsp_dec)
                inflight_q <= inflight_q + 1'b1;
            else if (!fire && rsp_dec)
                inflight_q <= inflight_q - 1'b1;
            // Abort flushes the FIFO; late responses only retire credit.
            if (kill) begin
                rptr_q <= wptr_q;
            end else begin
                if (push) wptr_q <= wptr_q + 1'b1;
                if (pop)  rptr_q <= rptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < fifoDepth; i++) fifo_q[i] <= '0;
        end else if (push) begin
            fifo_q[wptr_q[PW-1:0]] <= rsp_data;
        end
    end

`ifdef QRACC_DMA_CHECKSUM_EN
    logic [dataWidth-1:0] sum_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            sum_q <= '0;
        else if (accept)
            sum_q <= '0;
        else if (pop)
            sum_q <= sum_q + head;
    end

    assign checksum_o = sum_q;
`endif

endmodule

// File: tb/tb_qracc_bus_dma.sv
// tb_qracc_bus_dma: randomized bench with memory/accelerator responders and
// an address-indexed reference model of the expected destination stream.
module tb_qracc_bus_dma;

    logic        clk = 1'b0;
    logic        nrst;
    logic        start_i, dir_i, abort_i;
    logic [31:0] src_addr_i, dst_addr_i;
    logic [15:0] len_i;
    logic        busy_o, done_o, aborted_o;
    logic        mem_rd_req_o, mem_rd_gnt_i, mem_rd_valid_i;
    logic [31:0] mem_rd_addr_o, mem_rd_data_i;
    logic        mem_wr_en_o, mem_wr_ready_i;
    logic [31:0] mem_wr_addr_o, mem_wr_data_o;
    logic [31:0] bus_addr_o, bus_data_o, bus_data_i;
    logic        bus_wr_en_o, bus_rd_en_o, bus_rd_valid_i, bus_stall_i;
`ifdef QRACC_DMA_CHECKSUM_EN
    logic [31:0] checksum_o;
`endif

    always #5 clk = ~clk;

    qracc_bus_dma dut (
        .clk(clk), .nrst(nrst), .start_i(start_i), .dir_i(dir_i),
        .src_addr_i(src_addr_i), .dst_addr_i(dst_addr_i), .len_i(len_i),
        .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o),
        .aborted_o(aborted_o), .mem_rd_req_o(mem_rd_req_o),
        .mem_rd_addr_o(mem_rd_addr_o), .mem_rd_gnt_i(mem_rd_gnt_i),
        .mem_rd_valid_i(mem_rd_valid_i), .mem_rd_data_i(mem_rd_data_i),
        .mem_wr_en_o(mem_wr_en_o), .mem_wr_addr_o(mem_wr_addr_o),
        .mem_wr_data_o(mem_wr_data_o), .mem_wr_ready_i(mem_wr_ready_i),
        .bus_addr_o(bus_addr_o), .bus_wr_en_o(bus_wr_en_o),
        .bus_rd_en_o(bus_rd_en_o), .bus_data_o(bus_data_o),
        .bus_data_i(bus_data_i), .bus_rd_valid_i(bus_rd_valid_i),
`ifdef QRACC_DMA_CHECKSUM_EN
        .checksum_o(checksum_o),
`endif
        .bus_stall_i(bus_stall_i)
    );

    int total = 0, bad = 0;
    int cyc = 0, t0 = 0, lat = 2;
    int gnt_pct = 100, stall_pct = 0, ready_pct = 100;
    int stall_lo = -1, stall_hi = -2, ready_lo = -1, ready_hi = -2;
    logic [31:0] memv [logic [31:0]];
    logic [31:0] accv [logic [31:0]];
    logic [31:0] rd_a [$];
    int          rd_due [$];
    bit          bus_pend;
    logic [31:0] bus_pa;
    logic [31:0] dst_a [$], dst_d [$], src_a [$];
    int n_done, n_busy, n_strobe, viol, hold_err, out_cnt, pend_now;
    int first_wr, last_wr;
    bit req_hold, mw_hold;
    logic [31:0] req_hold_a, mw_hold_a, mw_hold_d;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (!memv.exists(a)) memv[a] = $urandom;
        return memv[a];
    endfunction

    function automatic logic [31:0] acc_val(input logic [31:0] a);
        if (!accv.exists(a)) accv[a] = $urandom;
        return accv[a];
    endfunction

    function automatic logic [31:0] exp_word(input bit d, input logic [31:0] s, input int i);
        return d ? acc_val(s + 32'(4 * i)) : mem_val(s + 32'(4 * i));
    endfunction

    function automatic bit in_win(input int r, input int lo, input int hi);
        return (r >= lo) && (r <= hi);
    endfunction

    task automatic clear_track();
        dst_a.delete(); dst_d.delete(); src_a.delete();
        n_done = 0; n_busy = 0; n_strobe = 0; viol = 0; hold_err = 0;
        first_wr = -1; last_wr = -1;
    endtask

    task automatic clear_env();
        rd_a.delete(); rd_due.delete();
        bus_pend = 0; out_cnt = 0; req_hold = 0; mw_hold = 0;
    endtask

    task automatic step(input bit st, input bit ab);
        bit iss, fire, dlv;
        @(negedge clk);
        cyc++;
        start_i = st;
        abort_i = ab;
        mem_rd_gnt_i = int'($urandom_range(99)) < gnt_pct;
        bus_stall_i = (int'($urandom_range(99)) < stall_pct) || in_win(cyc - t0, stall_lo, stall_hi);
        mem_wr_ready_i = (int'($urandom_range(99)) < ready_pct) && !in_win(cyc - t0, ready_lo, ready_hi);
        if (rd_a.size() > 0 && rd_due[0] <= cyc) begin
            mem_rd_valid_i = 1'b1;
            mem_rd_data_i = mem_val(rd_a.pop_front());
            void'(rd_due.pop_front());
        end else begin
            mem_rd_valid_i = 1'b0;
            mem_rd_data_i = $urandom;
        end
        bus_rd_valid_i = bus_pend;
        bus_data_i = bus_pend ? acc_val(bus_pa) : $urandom;
        bus_pend = 0;
        pend_now = rd_a.size();
        #1;
        iss = mem_rd_req_o || bus_rd_en_o;
        fire = (mem_rd_req_o && mem_rd_gnt_i) || bus_rd_en_o;
        dlv = bus_wr_en_o || (mem_wr_en_o && mem_wr_ready_i);
        if (iss && out_cnt >= 4) viol++;
        if (req_hold && !ab && (!mem_rd_req_o || mem_rd_addr_o !== req_hold_a)) hold_err++;
        if (mw_hold && !ab && (!mem_wr_en_o || mem_wr_addr_o !== mw_hold_a
                               || mem_wr_data_o !== mw_hold_d)) hold_err++;
        req_hold = mem_rd_req_o && !mem_rd_gnt_i;
        req_hold_a = mem_rd_addr_o;
        mw_hold = mem_wr_en_o && !mem_wr_ready_i;
        mw_hold_a = mem_wr_addr_o;
        mw_hold_d = mem_wr_data_o;
        if (mem_rd_req_o && mem_rd_gnt_i) begin
            rd_a.push_back(mem_rd_addr_o);
            rd_due.push_back(cyc + lat);
            src_a.push_back(mem_rd_addr_o);
        end
        if (bus_rd_en_o) begin
            bus_pend = 1;
            bus_pa = bus_addr_o;
            src_a.push_back(bus_addr_o);
        end
        if (bus_wr_en_o) begin
            dst_a.push_back(bus_addr_o);
            dst_d.push_back(bus_data_o);
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
        end
        if (mem_wr_en_o && mem_wr_ready_i) begin
            dst_a.push_back(mem_wr_addr_o);
            dst_d.push_back(mem_wr_data_o);
        end
        out_cnt = out_cnt + int'(fire) - int'(dlv);
        if (done_o) n_done++;
        if (busy_o) n_busy++;
        if (iss || bus_wr_en_o || mem_wr_en_o) n_strobe++;
    endtask

    task automatic run_xfer(input bit d, input logic [31:0] s, input logic [31:0] ds,
                            input logic [15:0] n, output bit ok);
        dir_i = d; src_addr_i = s; dst_addr_i = ds; len_i = n;
        clear_track();
        t0 = cyc + 1;
        step(1, 0);
        ok = 0;
        for (int k = 0; k < 3000 && !ok; k++) begin
            step(0, 0);
            if (n_done > 0) ok = 1;
        end
        step(0, 0);
        step(0, 0);
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({busy_o, done_o, aborted_o, mem_rd_req_o, mem_wr_en_o, bus_wr_en_o, bus_rd_en_o} !== 7'd0) begin
            bad++;
            $display("FAIL reset_ctl got=%b want=0", {busy_o, done_o, aborted_o, mem_rd_req_o, mem_wr_en_o, bus_wr_en_o, bus_rd_en_o});
        end
        total++;
        if ((mem_rd_addr_o | mem_wr_addr_o | mem_wr_data_o | bus_addr_o | bus_data_o) !== 32'd0) begin
            bad++;
            $display("FAIL reset_data got=%h want=0", mem_rd_addr_o | mem_wr_addr_o | bus_addr_o);
        end
        @(negedge clk);
        nrst = 1'b1;
        step(0, 1);
        step(0, 0);
        total++;
        if ({busy_o, aborted_o} !== 2'b00) begin
            bad++;
            $display("FAIL idle_abort got=%b want=00", {busy_o, aborted_o});
        end
    endtask

    task automatic test_write();
        bit ok;
        lat = 2;
        for (int i = 0; i < 8; i++) memv[32'h40 + 32'(4 * i)] = 32'h10 + 32'(i);
        run_xfer(0, 32'h40, 32'h100, 8, ok);
        total++;
        if (!ok || n_done !== 1) begin
            bad++;
            $display("FAIL wr_done got=%0d want=1 ok=%0d", n_done, ok);
        end
        total++;
        if (dst_a.size() !== 8) begin
            bad++;
            $display("FAIL wr_count got=%0d want=8", dst_a.size());
        end
        for (int i = 0; i < 8 && i < dst_a.size(); i++) begin
            total++;
            if (dst_a[i] !== 32'h100 + 32'(4 * i) || dst_d[i] !== 32'h10 + 32'(i)) begin
                bad++;
                $display("FAIL wr_word%0d got=%h/%h want=%h/%h", i, dst_a[i], dst_d[i],
                         32'h100 + 32'(4 * i), 32'h10 + 32'(i));
            end
        end
        total++;
        if (last_wr - first_wr !== 7) begin
            bad++;
            $display("FAIL wr_rate got=%0d want=7", last_wr - first_wr);
        end
`ifdef QRACC_DMA_CHECKSUM_EN
        total++;
        if (checksum_o !== 32'h9C) begin
            bad++;
            $display("FAIL wr_checksum got=%h want=9c", checksum_o);
        end
`endif
    endtask

    task automatic test_read();
        bit ok;
        ready_lo = 2; ready_hi = 4;
        run_xfer(1, 32'h100, 32'h2000, 5, ok);
        ready_lo = -1; ready_hi = -2;
        total++;
        if (!ok || n_done !== 1 || viol !== 0 || hold_err !== 0) begin
            bad++;
            $display("FAIL rd_ctl got=done%0d viol%0d hold%0d want=1/0/0", n_done, viol, hold_err);
        end
        total++;
        if (dst_a.size() !== 5) begin
            bad++;
            $display("FAIL rd_count got=%0d want=5", dst_a.size());
        end
        for (int i = 0; i < 5 && i < dst_a.size(); i++) begin
            total++;
            if (dst_a[i] !== 32'h2000 + 32'(4 * i) || dst_d[i] !== exp_word(1, 32'h100, i)) begin
                bad++;
                $display("FAIL rd_word%0d got=%h/%h want=%h/%h", i, dst_a[i], dst_d[i],
                         32'h2000 + 32'(4 * i), exp_word(1, 32'h100, i));
            end
        end
    endtask

    task automatic test_zero_len();
        dir_i = 0; len_i = 16'd0; src_addr_i = 32'h80; dst_addr_i = 32'h90;
        clear_track();
        step(1, 0);
        step(0, 0);
        total++;
        if (done_o !== 1'b1) begin
            bad++;
            $display("FAIL zero_done got=%b want=1", done_o);
        end
        repeat (4) step(0, 0);
        total++;
        if (n_done !== 1 || n_busy !== 0 || n_strobe !== 0) begin
            bad++;
            $display("FAIL zero_quiet got=done%0d busy%0d strobe%0d want=1/0/0", n_done, n_busy, n_strobe);
        end
    endtask

    task automatic test_stall();
        bit ok;
        lat = 1;
        stall_lo = 4; stall_hi = 13;
        run_xfer(0, 32'h3000, 32'h500, 16, ok);
        stall_lo = -1; stall_hi = -2;
        total++;
        if (!ok || viol !== 0 || hold_err !== 0 || n_done !== 1) begin
            bad++;
            $display("FAIL stall_ctl got=ok%0d viol%0d hold%0d done%0d want=1/0/0/1", ok, viol, hold_err, n_done);
        end
        total++;
        if (dst_a.size() !== 16) begin
            bad++;
            $display("FAIL stall_count got=%0d want=16", dst_a.size());
        end
        for (int i = 0; i < 16 && i < dst_a.size(); i++) begin
            total++;
            if (dst_a[i] !== 32'h500 + 32'(4 * i) || dst_d[i] !== exp_word(0, 32'h3000, i)) begin
                bad++;
                $display("FAIL stall_word%0d got=%h/%h want=%h/%h", i, dst_a[i], dst_d[i],
                         32'h500 + 32'(4 * i), exp_word(0, 32'h3000, i));
            end
        end
    endtask

    task automatic test_abort();
        bit ok;
        lat = 5;
        dir_i = 0; src_addr_i = 32'h800; dst_addr_i = 32'h600; len_i = 16'd8;
        clear_track();
        t0 = cyc + 1;
        step(1, 0);
        for (int k = 0; k < 200 && dst_a.size() < 3; k++) step(0, 0);
        step(0, 1);
        out_cnt = 0;
        step(0, 0);
        total++;
        if (busy_o !== 1'b0 || aborted_o !== 1'b1) begin
            bad++;
            $display("FAIL abort_flags got=busy%b ab%b want=0/1", busy_o, aborted_o);
        end
        len_i = 16'd2;
        step(1, 0);
        total++;
        if (pend_now < 1) begin
            bad++;
            $display("FAIL abort_inflight got=%0d want>=1", pend_now);
        end
        step(0, 0);
        total++;
        if (busy_o !== 1'b0) begin
            bad++;
            $display("FAIL abort_start_ignored got=%b want=0", busy_o);
        end
        for (int k = 0; k < 50 && rd_a.size() > 0; k++) step(0, 0);
        repeat (3) step(0, 0);
        total++;
        if (dst_a.size() !== 3 || n_done !== 0 || aborted_o !== 1'b1) begin
            bad++;
            $display("FAIL abort_quiet got=wr%0d done%0d ab%b want=3/0/1", dst_a.size(), n_done, aborted_o);
        end
        run_xfer(0, 32'h900, 32'h700, 3, ok);
        total++;
        if (!ok || aborted_o !== 1'b0 || dst_a.size() !== 3) begin
            bad++;
            $display("FAIL abort_restart got=ok%0d ab%b wr%0d want=1/0/3", ok, aborted_o, dst_a.size());
        end
        for (int i = 0; i < 3 && i < dst_a.size(); i++) begin
            total++;
            if (dst_d[i] !== exp_word(0, 32'h900, i)) begin
                bad++;
                $display("FAIL restart_word%0d got=%h want=%h", i, dst_d[i], exp_word(0, 32'h900, i));
            end
        end
`ifdef QRACC_DMA_CHECKSUM_EN
        total++;
        if (checksum_o !== exp_word(0, 32'h900, 0) + exp_word(0, 32'h900, 1) + exp_word(0, 32'h900, 2)) begin
            bad++;
            $display("FAIL restart_checksum got=%h", checksum_o);
        end
`endif
    endtask

    task automatic test_nrst_mid();
        lat = 2;
        dir_i = 0; src_addr_i = 32'hA00; dst_addr_i = 32'hB00; len_i = 16'd8;
        clear_track();
        t0 = cyc + 1;
        step(1, 0);
        repeat (4) step(0, 0);
        total++;
        if (busy_o !== 1'b1) begin
            bad++;
            $display("FAIL nrst_pre_busy got=%b want=1", busy_o);
        end
        @(negedge clk);
        nrst = 1'b0;
        #1;
        total++;
        if ({busy_o, done_o, aborted_o, mem_rd_req_o, mem_wr_en_o, bus_wr_en_o, bus_rd_en_o} !== 7'd0
            || (bus_addr_o | mem_rd_addr_o | bus_data_o) !== 32'd0) begin
            bad++;
            $display("FAIL nrst_outputs got=%b/%h want=0", {busy_o, done_o, mem_rd_req_o, bus_wr_en_o}, bus_addr_o);
        end
        clear_env();
        repeat (2) step(0, 0);
        nrst = 1'b1;
        clear_track();
        repeat (5) step(0, 0);
        total++;
        if (n_strobe !== 0 || n_busy !== 0 || n_done !== 0) begin
            bad++;
            $display("FAIL nrst_quiet got=strobe%0d busy%0d done%0d want=0", n_strobe, n_busy, n_done);
        end
    endtask

    task automatic test_busy_start();
        bit ok;
        lat = 2;
        dir_i = 0; src_addr_i = 32'hC00; dst_addr_i = 32'hD00; len_i = 16'd4;
        clear_track();
        t0 = cyc + 1;
        step(1, 0);
        step(0, 0);
        dir_i = 1; src_addr_i = 32'h5000; dst_addr_i = 32'h7000; len_i = 16'd9;
        step(1, 0);
        ok = 0;
        for (int k = 0; k < 200 && !ok; k++) begin
            step(0, 0);
            if (n_done > 0) ok = 1;
        end
        repeat (4) step(0, 0);
        total++;
        if (!ok || n_done !== 1 || dst_a.size() !== 4 || src_a.size() !== 4) begin
            bad++;
            $display("FAIL busy_start got=done%0d wr%0d src%0d want=1/4/4", n_done, dst_a.size(), src_a.size());
        end
        for (int i = 0; i < 4 && i < dst_a.size(); i++) begin
            total++;
            if (dst_a[i] !== 32'hD00 + 32'(4 * i) || dst_d[i] !== exp_word(0, 32'hC00, i)) begin
                bad++;
                $display("FAIL busy_word%0d got=%h/%h", i, dst_a[i], dst_d[i]);
            end
        end
    endtask

    task automatic test_wrap();
        bit ok;
        run_xfer(0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 2, ok);
        total++;
        if (!ok || src_a.size() !== 2 || dst_a.size() !== 2) begin
            bad++;
            $display("FAIL wrap_count got=src%0d dst%0d want=2/2", src_a.size(), dst_a.size());
        end else begin
            total++;
            if (src_a[1] !== 32'h0 || dst_a[1] !== 32'h0 || dst_a[0] !== 32'hFFFF_FFFC) begin
                bad++;
                $display("FAIL wrap_addr got=%h/%h want=0/0", src_a[1], dst_a[1]);
            end
            total++;
            if (dst_d[0] !== mem_val(32'hFFFF_FFFC) || dst_d[1] !== mem_val(32'h0)) begin
                bad++;
                $display("FAIL wrap_data got=%h/%h", dst_d[0], dst_d[1]);
            end
        end
    endtask

    task automatic test_random();
        bit ok, d;
        logic [31:0] s, ds, sum;
        int n, errs;
        for (int it = 0; it < 8; it++) begin
            d = 1'($urandom_range(1));
            n = int'($urandom_range(24, 1));
            s = $urandom & 32'hFFFF_FFFC;
            ds = $urandom & 32'hFFFF_FFFC;
            lat = int'($urandom_range(4, 1));
            gnt_pct = int'($urandom_range(100, 40));
            stall_pct = int'($urandom_range(50));
            ready_pct = int'($urandom_range(100, 40));
            run_xfer(d, s, ds, 16'(n), ok);
            total++;
            if (!ok || n_done !== 1 || viol !== 0 || hold_err !== 0 || dst_a.size() !== n) begin
                bad++;
                $display("FAIL rand%0d_ctl got=ok%0d done%0d viol%0d hold%0d wr%0d want=1/1/0/0/%0d",
                         it, ok, n_done, viol, hold_err, dst_a.size(), n);
            end
            errs = 0;
            sum = 0;
            for (int i = 0; i < n; i++) begin
                sum = sum + exp_word(d, s, i);
                if (i >= dst_a.size()) errs++;
                else if (dst_a[i] !== ds + 32'(4 * i) || dst_d[i] !== exp_word(d, s, i)) errs++;
            end
            total++;
            if (errs !== 0) begin
                bad++;
                $display("FAIL rand%0d_seq got=%0d bad words want=0", it, errs);
            end
`ifdef QRACC_DMA_CHECKSUM_EN
            total++;
            if (checksum_o !== sum) begin
                bad++;
                $display("FAIL rand%0d_checksum got=%h want=%h", it, checksum_o, sum);
            end
`endif
        end
        gnt_pct = 100; stall_pct = 0; ready_pct = 100;
    endtask

    initial begin
        nrst = 1'b0;
        start_i = 0; dir_i = 0; abort_i = 0; len_i = 0;
        src_addr_i = 0; dst_addr_i = 0;
        mem_rd_gnt_i = 0; mem_rd_valid_i = 0; mem_rd_data_i = 0;
        mem_wr_ready_i = 0; bus_data_i = 0; bus_rd_valid_i = 0; bus_stall_i = 0;
        clear_env();
        clear_track();
        test_reset();
        test_write();
        test_read();
        test_zero_len();
        test_stall();
        test_abort();
        test_nrst_mid();
        test_busy_start();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/qracc_bus_dma.md
Name: qracc_bus_dma

Overview:
- Bus-master DMA engine upstream of the accelerator top. It moves blocks of 32-bit words between a system memory port and the accelerator's data interface.
- Write direction (mem -> accel): loads activations, weights, scaler/bias words and CSR images. Read direction (accel -> mem): drains results from the activation buffer window.
- A small internal FIFO decouples the memory and bus sides. The block replaces host-driven word-by-word bus traffic.

Parameters:
- dataWidth, 32, word width on both the bus and memory sides.
- addrWidth, 32, byte-address width on both sides.
- lenWidth, 16, width of the transfer word count.
- fifoDepth, 4, internal FIFO depth in words; must be a power of two and at least 2.
- addrStride, 4, byte increment per word; applied to both source and destination addresses.

Ports:
- clk  in  1  clock
- nrst  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle pulse; latches the transfer descriptor
- dir_i  in  1  0 = mem->accel write, 1 = accel->mem read
- src_addr_i  in  addrWidth  start address on the source side
- dst_addr_i  in  addrWidth  start address on the destination side
- len_i  in  lenWidth  number of words to move
- abort_i  in  1  synchronous abort request
- busy_o  out  1  high while the transfer is active
- done_o  out  1  one-cycle completion pulse
- aborted_o  out  1  sticky flag; cleared by the next accepted start
- mem_rd_req_o  out  1  memory read request
- mem_rd_addr_o  out  addrWidth  memory read address
- mem_rd_gnt_i  in  1  memory read request accepted
- mem_rd_valid_i  in  1  memory read data valid; in-order, any latency
- mem_rd_data_i  in  dataWidth  memory read data
- mem_wr_en_o  out  1  memory write strobe
- mem_wr_addr_o  out  addrWidth  memory write address
- mem_wr_data_o  out  dataWidth  memory write data
- mem_wr_ready_i  in  1  memory accepts the write this cycle
- bus_addr_o  out  addrWidth  accelerator bus address
- bus_wr_en_o  out  1  accelerator bus write strobe
- bus_rd_en_o  out  1  accelerator bus read strobe
- bus_data_o  out  dataWidth  data to the accelerator (bus data_in)
- bus_data_i  in  dataWidth  data from the accelerator (bus data_out)
- bus_rd_valid_i  in  1  accelerator read data valid; exactly 1 cycle after bus_rd_en_o
- bus_stall_i  in  1  accelerator cannot accept a bus op this cycle

Behaviour:
- Reset: all outputs are 0, FSM is IDLE, FIFO is empty.
- FSM states: IDLE, XFER, DRAIN, DONE.
  - IDLE -> XFER on start_i with len_i != 0. The descriptor is registered and aborted_o is cleared.
  - start_i with len_i == 0 goes to DONE: done_o pulses the next cycle, and no memory or bus transaction is issued.
  - start_i while busy_o is high is ignored.
  - XFER: issues source-side requests until len_i requests have been issued, then moves to DRAIN.
  - DRAIN: waits until all len_i words have been written on the destination side and the FIFO is empty, then moves to DONE.
  - DONE: done_o is high for exactly one cycle, busy_o drops in the same cycle, then the FSM returns to IDLE.
- busy_o is high in XFER and DRAIN only.
- Credit rule: source-side requests in flight plus FIFO occupancy never exceed fifoDepth. The FIFO must never overflow, whatever the read latency.
- Write direction (dir 0):
  - mem_rd_req_o is held with a stable address until mem_rd_gnt_i; the address then advances by addrStride.
  - Returned words are pushed into the FIFO.
  - When the FIFO is non-empty and bus_stall_i is low, pop one word, assert bus_wr_en_o for one cycle with bus_data_o = the word and bus_addr_o = current dst, then advance dst.
- Read direction (dir 1):
  - bus_rd_en_o is asserted for one cycle when bus_stall_i is low and credit is available; bus_addr_o = current src, then src advances.
  - The word on bus_data_i is pushed when bus_rd_valid_i is high.
  - mem_wr_en_o is held with stable addr/data until mem_wr_ready_i.
- Throughput: 1 word/cycle sustained when there are no stalls and grants come every cycle.
- Arithmetic:
  - Address counters wrap modulo 2^addrWidth with no error.
  - Word counters are lenWidth wide; the maximum len is 2^lenWidth-1.
- FIFO: simultaneous push and pop when full or empty is legal, and occupancy is unchanged.
- abort_i:
  - From XFER or DRAIN, the next state is IDLE. The FIFO is flushed, aborted_o is set, and done_o does not pulse.
  - New requests stop in the same cycle.
  - Memory or bus read data that arrives after the abort is discarded until the in-flight count reaches 0. start_i is ignored until then.
  - abort_i in IDLE has no effect.
- nrst asserted mid-transfer clears all state immediately; no outstanding-response tracking survives reset.

Optional Feature:
- Macro: QRACC_DMA_CHECKSUM_EN.
- Enabled:
  - Adds output checksum_o [dataWidth].
  - Holds the modulo-2^32 sum of every word popped from the FIFO in the current transfer.
  - Cleared on accepted start and valid from the done_o cycle until the next accepted start.
  - Not updated by discarded post-abort data.
- Disabled: the port and the adder are absent, and behaviour is otherwise identical.

Test Plan:
- Write 8 words (mem data 0x10..0x17, dst 0x100, grant every cycle, 2-cycle read latency) -> bus_wr_en_o on 8 cycles with addresses 0x100..0x11C and data 0x10..0x17 in order. done_o pulses once. With checksum enabled, checksum_o = 0x9C.
- Read 5 words (src 0x100, dst 0x2000), bus_rd_valid_i one cycle after each bus_rd_en_o, mem_wr_ready_i low on cycles 2-4 -> mem writes at 0x2000..0x2010 with correct data. bus_rd_en_o stalls on credit so the FIFO never exceeds 4 entries.
- len_i = 0 -> no req/en strobes, done_o pulses 1 cycle after start_i, busy_o stays 0.
- bus_stall_i high for 10 cycles mid write transfer, read latency 1, len 16 -> no mem_rd_req_o while 4 entries are occupied or pending. All 16 words are delivered in order with no loss or duplication.
- abort_i after the 3rd of 8 words, with 2 reads in flight -> busy_o = 0 the next cycle, aborted_o = 1, no done_o. The late mem data produces no bus write, and start_i is ignored until the in-flight count reaches 0.
- nrst pulsed mid-transfer; a second start_i while busy; address 0xFFFF_FFFC with len 2 -> outputs return to 0 on reset; the second start is ignored; the address wraps to 0x0000_0000.
